// File: rtl/mem_arbiter.sv
// Two-port (IFU / LSU) arbiter sharing one data-memory port; one outstanding transaction with watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_wen,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [7:0]        ls_req_wmask,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [15:0]       cnt_q;
  logic              err_q;

  logic grant_ls, grant_if, accept;
  logic is_idle, rsp_hit, wd_fire, deliver;

`ifdef MEM_ARB_RR_EN
  logic last_q;  // owner of the most recent grant, 0 = IF

  always_comb begin
    grant_ls = ls_req_valid;
    grant_if = if_req_valid & ~ls_req_valid;
    if (ls_req_valid && if_req_valid) begin
      grant_ls = ~last_q;
      grant_if = last_q;
    end
  end
`else
  assign grant_ls = ls_req_valid;
  assign grant_if = if_req_valid & ~ls_req_valid;
`endif

  assign is_idle      = (state_q == S_IDLE);
  assign ls_req_ready = is_idle & grant_ls;
  assign if_req_ready = is_idle & grant_if;
  assign accept       = ls_req_ready | if_req_ready;

  // A response arriving on the watchdog's last cycle still wins over the abort.
  assign rsp_hit = (state_q == S_WAIT) & mem_rsp_valid;
  assign wd_fire = ~is_idle & (cnt_q == CNT_LAST) & ~rsp_hit;
  assign deliver = rsp_hit | wd_fire;

  assign if_rsp_valid = deliver & ~owner_q;
  assign ls_rsp_valid = deliver & owner_q;
  assign if_rsp_data  = (rsp_hit & ~owner_q) ? mem_rsp_data : '0;
  assign ls_rsp_data  = (rsp_hit & owner_q) ? mem_rsp_data : '0;

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign busy        = ~is_idle;
  assign timeout_err = err_q | wd_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            owner_q <= grant_ls;
            addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
            wen_q   <= grant_ls & ls_req_wen;
            wdata_q <= grant_ls ? ls_req_wdata : '0;
            wmask_q <= grant_ls ? ls_req_wmask : 8'h00;
            cnt_q   <= '0;
            state_q <= S_REQ;
`ifdef MEM_ARB_RR_EN
            last_q  <= grant_ls;
`endif
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 16'd1;
          if (wd_fire) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (mem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (rsp_hit) begin
            state_q <= S_IDLE;
          end else if (wd_fire) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven transactions plus backpressure, watchdog and async-reset sequences.
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_valid = 1'b0, ls_req_valid = 1'b0;
  logic [AW-1:0] if_req_addr = '0, ls_req_addr = '0;
  logic          ls_req_wen = 1'b0;
  logic [DW-1:0] ls_req_wdata = '0;
  logic [7:0]    ls_req_wmask = '0;
  logic          mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;

  logic          if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid;
  logic [DW-1:0] if_rsp_data, ls_rsp_data, mem_req_wdata;
  logic          mem_req_valid, mem_req_wen, busy, timeout_err;
  logic [AW-1:0] mem_req_addr;
  logic [7:0]    mem_req_wmask;

  // Watchdog instance (TIMEOUT = 8) with its own request valids; shares the memory-side inputs.
  logic          t_if_req_valid = 1'b0, t_ls_req_valid = 1'b0;
  logic          t_if_req_ready, t_ls_req_ready, t_if_rsp_valid, t_ls_rsp_valid;
  logic [DW-1:0] t_if_rsp_data, t_ls_rsp_data, t_mem_req_wdata;
  logic          t_mem_req_valid, t_mem_req_wen, t_busy, t_timeout_err;
  logic [AW-1:0] t_mem_req_addr;
  logic [7:0]    t_mem_req_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(t_if_req_valid), .if_req_ready(t_if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(t_if_rsp_valid), .if_rsp_data(t_if_rsp_data),
    .ls_req_valid(t_ls_req_valid), .ls_req_ready(t_ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(t_ls_rsp_valid), .ls_rsp_data(t_ls_rsp_data),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(t_mem_req_addr),
    .mem_req_wen(t_mem_req_wen), .mem_req_wdata(t_mem_req_wdata), .mem_req_wmask(t_mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(t_busy), .timeout_err(t_timeout_err)
  );

  typedef struct {
    logic          ifv;
    logic [AW-1:0] ifa;
    logic          lsv;
    logic [AW-1:0] lsa;
    logic          wen;
    logic [DW-1:0] wd;
    logic [7:0]    wm;
    logic [DW-1:0] rd;
    logic          own;  // expected winner, 1 = LS
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept at N, mem ready at N+1, response at N+2, idle at N+3.
  task automatic run_txn(input vec_t v, input int idx);
    @(posedge clk); #1;
    if_req_valid = v.ifv; if_req_addr = v.ifa;
    ls_req_valid = v.lsv; ls_req_addr = v.lsa;
    ls_req_wen = v.wen; ls_req_wdata = v.wd; ls_req_wmask = v.wm;
    @(negedge clk);
    chk("ls_req_ready", ls_req_ready, v.own);
    chk("if_req_ready", if_req_ready, !v.own);
    @(posedge clk); #1;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    chk("mem_req_valid", mem_req_valid, 1'b1);
    chk("mem_req_addr", mem_req_addr, v.own ? v.lsa : v.ifa);
    chk("mem_req_wen", mem_req_wen, v.own & v.wen);
    chk("mem_req_wmask", mem_req_wmask, v.own ? v.wm : 8'h00);
    if (v.own) chk("mem_req_wdata", mem_req_wdata, v.wd);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = v.rd;
    @(negedge clk);
    chk("owner_rsp_valid", v.own ? ls_rsp_valid : if_rsp_valid, 1'b1);
    chk("owner_rsp_data", v.own ? ls_rsp_data : if_rsp_data, v.rd);
    chk("other_rsp_valid", v.own ? if_rsp_valid : ls_rsp_valid, 1'b0);
    chk("wait_mem_req_valid", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    $display("txn %0d: owner=%s addr=%h wen=%0d rsp=%h", idx, v.own ? "LS" : "IF",
             v.own ? v.lsa : v.ifa, v.own & v.wen, v.rd);
  endtask

  initial begin
    vecs[0] = '{1'b0, 64'h0, 1'b1, 64'h8000_0100, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b1};
    vecs[1] = '{1'b0, 64'h0, 1'b1, 64'h8000_0200, 1'b0, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b1};
    vecs[2] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h13, 1'b0};
`ifdef MEM_ARB_RR_EN
    vecs[3] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_1000, 1'b1, 64'hA5A5_0001, 8'hFF, 64'h0, 1'b1};
    vecs[4] = '{1'b1, 64'h8000_0008, 1'b1, 64'h8000_1008, 1'b0, 64'h0, 8'hF0, 64'h0000_0000_0010_0093, 1'b0};
    vecs[5] = '{1'b1, 64'h8000_000C, 1'b1, 64'h8000_1010, 1'b1, 64'hA5A5_0003, 8'h03, 64'h0, 1'b1};
    vecs[6] = '{1'b1, 64'h8000_0010, 1'b1, 64'h8000_1018, 1'b0, 64'h0, 8'hFF, 64'h0000_0000_0020_8133, 1'b0};
`else
    vecs[3] = '{1'b1, 64'h8000_0004, 1'b1, 64'h8000_1000, 1'b1, 64'hA5A5_0001, 8'hFF, 64'h0, 1'b1};
    vecs[4] = '{1'b1, 64'h8000_0008, 1'b1, 64'h8000_1008, 1'b0, 64'h0, 8'hF0, 64'hCAFE_F00D_0000_0004, 1'b1};
    vecs[5] = '{1'b1, 64'h8000_000C, 1'b1, 64'h8000_1010, 1'b1, 64'hA5A5_0003, 8'h03, 64'h0, 1'b1};
    vecs[6] = '{1'b1, 64'h8000_0010, 1'b1, 64'h8000_1018, 1'b0, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1};
`endif
    vecs[7] = '{1'b1, 64'h8000_0040, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0000_0000_00A0_0093, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_if_req_ready", if_req_ready, 1'b0);
    chk("rst_ls_req_ready", ls_req_ready, 1'b0);
    chk("rst_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 2'b00);
    chk("rst_rsp_data", if_rsp_data | ls_rsp_data, 64'h0);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_req_fields", mem_req_addr | mem_req_wdata | {55'h0, mem_req_wen, mem_req_wmask}, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Backpressure: 10 cycles of mem_req_ready low, stray response in REQ ignored
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0080;
    @(negedge clk);
    chk("bp_if_req_ready", if_req_ready, 1'b1);
    @(posedge clk); #1;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_2000; ls_req_wen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        mem_rsp_valid = (k == 4);
        mem_rsp_data  = 64'hBAD0_BAD0;
      end
      @(negedge clk);
      chk("bp_mem_req_valid", mem_req_valid, 1'b1);
      chk("bp_mem_req_addr", mem_req_addr, 64'h8000_0080);
      chk("bp_mem_req_wen", mem_req_wen, 1'b0);
      chk("bp_readies", {if_req_ready, ls_req_ready}, 2'b00);
      chk("bp_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 2'b00);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_wen = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_0000_0517;
    @(negedge clk);
    chk("bp_if_rsp_valid", if_rsp_valid, 1'b1);
    chk("bp_if_rsp_data", if_rsp_data, 64'h517);
    chk("bp_ls_rsp_valid", ls_rsp_valid, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    @(negedge clk);
    chk("bp_busy_after", busy, 1'b0);
    $display("txn backpressure: owner=IF addr=%h 10 stall cycles", 64'h8000_0080);

    // Watchdog (TIMEOUT = 8): memory accepts but never responds
    @(posedge clk); #1;
    t_if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
    @(negedge clk);
    chk("to_if_req_ready", t_if_req_ready, 1'b1);
    @(posedge clk); #1;
    t_if_req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
      end
      @(negedge clk);
      if (k < 8) begin
        chk("to_rsp_early", t_if_rsp_valid, 1'b0);
        chk("to_err_early", t_timeout_err, 1'b0);
        chk("to_busy", t_busy, 1'b1);
      end else begin
        chk("to_rsp_valid", t_if_rsp_valid, 1'b1);
        chk("to_rsp_data", t_if_rsp_data, 64'h0);
        chk("to_err", t_timeout_err, 1'b1);
        chk("to_ls_rsp_valid", t_ls_rsp_valid, 1'b0);
      end
      if (k == 1) begin
        chk("to_mem_req_valid", t_mem_req_valid, 1'b1);
        mem_req_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("to_busy_after", t_busy, 1'b0);
    chk("to_err_sticky", t_timeout_err, 1'b1);
    chk("to_rsp_cleared", t_if_rsp_valid, 1'b0);
    // Next request on the watchdog instance completes normally
    @(posedge clk); #1;
    t_ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0300; ls_req_wen = 1'b0; ls_req_wmask = 8'h00;
    @(negedge clk);
    chk("to_next_ready", t_ls_req_ready, 1'b1);
    @(posedge clk); #1;
    t_ls_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h7777_0000_1111_2222;
    @(negedge clk);
    chk("to_next_rsp_valid", t_ls_rsp_valid, 1'b1);
    chk("to_next_rsp_data", t_ls_rsp_data, 64'h7777_0000_1111_2222);
    chk("to_next_err_sticky", t_timeout_err, 1'b1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    $display("txn timeout: owner=IF addr=%h aborted after 8 cycles, follow-up LS load ok", 64'h8000_0100);

    // Async reset while waiting for a response
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0200;
    @(posedge clk); #1;
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("ar_busy_before", busy, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h55;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_mem_req_valid", mem_req_valid, 1'b0);
    chk("ar_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 2'b00);
    chk("ar_mem_req_addr", mem_req_addr, 64'h0);
    chk("ar_timeout_err", t_timeout_err, 1'b0);
    @(negedge clk);
    chk("ar_rsp_in_reset", if_rsp_valid, 1'b0);
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    rst_n = 1'b1;
    $display("txn async-reset: pending fetch at %h dropped", 64'h8000_0200);
    run_txn(vecs[2], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and transaction sequencer for the multi-cycle NPC core. It shares the single data-memory port between the instruction fetch path (IFU) and the load/store path driven by the decoder's MemRead/MemWrite/mask_type outputs. It grants one requester at a time, keeps exactly one transaction outstanding, and routes the response back to its owner. A watchdog flags a memory that never responds.

## Interface
Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, read/write data width
- TIMEOUT, 255, maximum cycles from grant to response before abort; range 2..65535

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IFU fetch request
- if_req_ready  out  1  IFU request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  one-cycle fetch response strobe
- if_rsp_data  out  DATA_W  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_req_addr  in  ADDR_W  load/store address
- ls_req_wen  in  1  1 = store, 0 = load
- ls_req_wdata  in  DATA_W  store data
- ls_req_wmask  in  8  store byte mask
- ls_rsp_valid  out  1  one-cycle load data / store ack strobe
- ls_rsp_data  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  out  ADDR_W/1/DATA_W/8  registered request fields
- mem_rsp_valid  in  1  memory response strobe; every request, store or load, gets exactly one
- mem_rsp_data  in  DATA_W  response data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Winner selection is combinational. Fixed priority: LSU over IFU.
  - The winner's *_req_ready = 1 in the same cycle. The loser's ready = 0.
  - On the valid&ready handshake: latch addr/wen/wdata/wmask and the owner bit (0 = IF, 1 = LS), clear the watchdog, and go to REQ.
  - IF requests latch wen = 0 and wmask = 0.
- REQ: mem_req_valid = 1 with the latched fields held stable. On mem_req_ready, go to WAIT.
- WAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid: the owner's *_rsp_valid = 1 for that cycle, and *_rsp_data = mem_rsp_data (combinational pass-through). Go to IDLE.
  - The non-owner's rsp_valid stays 0.
- Requester ready is 0 in REQ and WAIT. No new request is accepted while a transaction is pending.
- mem_rsp_valid in IDLE or REQ is ignored.
- Watchdog:
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT without a response: set timeout_err, pulse the owner's rsp_valid with rsp_data = 0, and go to IDLE.
  - If the memory is still in the REQ state, mem_req_valid drops. This is the only legal retraction.
  - timeout_err is cleared only by reset.
- If a response and the timeout occur in the same cycle, the response wins and no error is raised.

## Timing
- Reset values: state IDLE. All outputs 0: both ready signals (the combinational ready then follows the inputs), rsp_valid, rsp_data, all mem_req_* signals, busy, timeout_err. Counter and owner are 0.
- Reset asserted mid-transaction: return to IDLE immediately and drop the pending transaction. No response is delivered.
- Handshake accepted in cycle N → mem_req_valid is high from N+1.
- With mem_req_ready at N+1 and mem_rsp_valid at N+2, the owner's rsp_valid is at N+2, state is IDLE at N+3, and the next accept is at N+3. The minimum issue interval is 3 cycles.
- A memory response must arrive at least 1 cycle after the request handshake. A response in the same cycle as the handshake is ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-owner register, reset to IF, is updated on each handshake.
  - When both requesters are valid in IDLE, the one not granted last wins.
- MEM_ARB_RR_EN undefined: fixed priority, LSU always wins. The last-owner register is not built.

## Test plan
- Single fetch: if_req_valid = 1, addr 0x8000_0000; memory ready at N+1, response 0x0000_0013 at N+2 → if_rsp_valid pulse at N+2 with data 0x13, ls_rsp_valid = 0, busy low at N+3.
- Store ack: ls store, addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F → mem_req_wen = 1 and the fields match; ack → ls_rsp_valid for 1 cycle.
- Contention: both valid for 4 transactions.
  - Fixed priority: all 4 are LS while ls_req_valid stays high.
  - With MEM_ARB_RR_EN: grants go LS, IF, LS, IF (the first contention goes to LS because last owner resets to IF).
- Backpressure: mem_req_ready held low for 10 cycles → mem_req_valid and the fields are stable, both ready signals are 0, and the grant completes on ready.
- Timeout with TIMEOUT = 8: no mem_rsp_valid → at the 8th cycle after accept, timeout_err = 1 and stays 1, the owner's rsp_valid pulses with data 0, and the next request is accepted normally.
- Async reset asserted in WAIT → all outputs 0 immediately and no rsp_valid. After release, a fresh fetch completes in 3 cycles.
